// File: rtl/bram_wide_pkg.sv
// bram_wide_pkg: shared state encoding, latency constants and address helper
// for the wide-word BRAM front end.
`default_nettype none

package bram_wide_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LAT_LOW  = 1;
  localparam int LAT_HIGH = 2;

  function automatic int unsigned base_addr(input int unsigned addr, input int unsigned pieces);
    return addr * pieces;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_read_collector.sv
// bram_read_collector: tracks in-flight read pieces through the BRAM latency
// and assembles them into the wide response word.
`default_nettype none

module bram_read_collector #(
  parameter int BRAM_WIDTH   = 64,
  parameter int PIECES       = 4,
  parameter int READ_LATENCY = 2,
  parameter int TAG_W        = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         issue_valid,
  input  logic [TAG_W-1:0]             issue_tag,
  input  logic [BRAM_WIDTH-1:0]        bram_dout,
  output logic                         last_captured,
  output logic [BRAM_WIDTH*PIECES-1:0] rsp_data_out
);

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [TAG_W-1:0]        tag_pipe [READ_LATENCY];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
      rsp_data_out <= '0;
    end else begin
      vld_pipe[0] <= issue_valid;
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      // The oldest stage lines up with the BRAM data for that piece.
      if (vld_pipe[READ_LATENCY-1])
        rsp_data_out[tag_pipe[READ_LATENCY-1]*BRAM_WIDTH +: BRAM_WIDTH] <= bram_dout;
    end
  end

  assign last_captured = vld_pipe[READ_LATENCY-1] &&
                         (tag_pipe[READ_LATENCY-1] == TAG_W'(PIECES - 1));

endmodule

`default_nettype wire

// File: rtl/bram_wide_port.sv
// bram_wide_port: splits wide-word requests into per-piece BRAM port accesses
// with masked writes, latency-aware read assembly and range checking.
`default_nettype none

module bram_wide_port
  import bram_wide_pkg::*;
#(
  parameter int ADDRS          = 24,
  parameter int BRAM_WIDTH     = 64,
  parameter int PIECES         = 4,
  parameter int READ_LATENCY   = 2,
  localparam int ADDR_SIZE      = $clog2(ADDRS),
  localparam int BRAM_ADDR_SIZE = $clog2(ADDRS * PIECES),
  localparam int WIDTH          = BRAM_WIDTH * PIECES
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [BRAM_WIDTH-1:0]     bram_dout,
  output logic [BRAM_ADDR_SIZE-1:0] bram_addr,
  output logic                      bram_we,
  output logic                      bram_regce,
  output logic [BRAM_WIDTH-1:0]     bram_din,
  input  logic                      req_valid_in,
  output logic                      req_ready_out,
  input  logic                      req_write_in,
  input  logic [ADDR_SIZE-1:0]      req_addr_in,
  input  logic [WIDTH-1:0]          req_data_in,
  input  logic [PIECES-1:0]         req_mask_in,
  output logic                      done_out,
  output logic                      err_out,
  output logic [WIDTH-1:0]          rsp_data_out
);

  localparam int TAG_W = (PIECES > 1) ? $clog2(PIECES) : 1;
  localparam logic [TAG_W-1:0] LAST_PIECE = TAG_W'(PIECES - 1);

  generate
    if (READ_LATENCY != LAT_LOW && READ_LATENCY != LAT_HIGH) begin : g_bad_latency
      $error("bram_wide_port: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  state_t            state;
  logic [TAG_W-1:0]  piece;
  logic              is_write;
  logic [WIDTH-1:0]  data_q;
  logic [PIECES-1:0] mask_q;
  logic              last_captured;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      piece         <= '0;
      is_write      <= 1'b0;
      data_q        <= '0;
      mask_q        <= '0;
      req_ready_out <= 1'b0;
      bram_addr     <= '0;
      bram_we       <= 1'b0;
      bram_regce    <= 1'b0;
      bram_din      <= '0;
      done_out      <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in && req_ready_out) begin
            req_ready_out <= 1'b0;
            is_write      <= req_write_in;
            if (32'(req_addr_in) >= ADDRS) begin
              state <= DONE;
            end else begin
              // Piece 0 goes on the bus at the acceptance edge; the rest shift out behind it.
              state      <= ISSUE;
              piece      <= '0;
              bram_addr  <= BRAM_ADDR_SIZE'(base_addr(32'(req_addr_in), PIECES));
              bram_din   <= req_data_in[BRAM_WIDTH-1:0];
              bram_we    <= req_write_in & req_mask_in[0];
              bram_regce <= 1'b1;
              data_q     <= req_data_in >> BRAM_WIDTH;
              mask_q     <= req_mask_in >> 1;
            end
          end else begin
            req_ready_out <= 1'b1;
          end
        end
        ISSUE: begin
          if (piece == LAST_PIECE) begin
            bram_we <= 1'b0;
            if (is_write) begin
              state      <= DONE;
              done_out   <= 1'b1;
              bram_regce <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            piece     <= piece + 1'b1;
            bram_addr <= bram_addr + 1'b1;
            bram_din  <= data_q[BRAM_WIDTH-1:0];
            bram_we   <= is_write & mask_q[0];
            data_q    <= data_q >> BRAM_WIDTH;
            mask_q    <= mask_q >> 1;
          end
        end
        DRAIN: begin
          if (last_captured) begin
            state      <= DONE;
            done_out   <= 1'b1;
            bram_regce <= 1'b0;
          end
        end
        DONE: begin
          // Completions arrive with done_out already set; a rejected request raises it here.
          if (done_out) begin
            done_out      <= 1'b0;
            err_out       <= 1'b0;
            state         <= IDLE;
            req_ready_out <= 1'b1;
          end else begin
            done_out <= 1'b1;
            err_out  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_read_collector #(
    .BRAM_WIDTH  (BRAM_WIDTH),
    .PIECES      (PIECES),
    .READ_LATENCY(READ_LATENCY),
    .TAG_W       (TAG_W)
  ) u_collector (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .issue_valid  ((state == ISSUE) && !is_write),
    .issue_tag    (piece),
    .bram_dout    (bram_dout),
    .last_captured(last_captured),
    .rsp_data_out (rsp_data_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_bram_wide_port.sv
// tb_bram_wide_port: directed bench driving a READ_LATENCY=2 and a READ_LATENCY=1
// instance in lockstep, each against its own behavioural read-first BRAM.
`default_nettype none

module tb_bram_wide_port;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [4:0]   req_addr = '0;
  logic [255:0] req_data = '0;
  logic [3:0]   req_mask = '0;

  logic [63:0]  dout0, dout1, din0, din1, ram0;
  logic [6:0]   addr0, addr1;
  logic         we0, we1, regce0, regce1, ready0, ready1, done0, done1, err0, err1;
  logic [255:0] rsp0, rsp1;

  logic [63:0]  mem0 [0:95];
  logic [63:0]  mem1 [0:95];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_last = 0;
  int acc_prev = 0;
  int we_cnt0 = 0;

  localparam logic [255:0] D1    = 256'hBEAD0000BE0011228888888888888888BEAD0000BE0011228888888888888888;
  localparam logic [255:0] PRE   = 256'h1212121200001212777777777777777712121212000012127777777777777777;
  localparam logic [255:0] MSKD  = 256'h1212121200001212000000000000000012121212000012120000000000000000;
  localparam logic [255:0] NEWW  = 256'hD3D3D3D3D3D3D3D3C2C2C2C2C2C2C2C2B1B1B1B1B1B1B1B1A0A0A0A0A0A0A0A0;
  localparam logic [255:0] AFTR  = 256'h12121212000012120000000000000000B1B1B1B1B1B1B1B1A0A0A0A0A0A0A0A0;
  localparam logic [255:0] W3    = {4{64'h3333333333333333}};
  localparam logic [255:0] W4    = {4{64'h4444444444444444}};

  always #5 clk = ~clk;

  bram_wide_port #(.ADDRS(24), .BRAM_WIDTH(64), .PIECES(4), .READ_LATENCY(2)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .bram_dout(dout0), .bram_addr(addr0), .bram_we(we0),
    .bram_regce(regce0), .bram_din(din0), .req_valid_in(req_valid), .req_ready_out(ready0),
    .req_write_in(req_write), .req_addr_in(req_addr), .req_data_in(req_data),
    .req_mask_in(req_mask), .done_out(done0), .err_out(err0), .rsp_data_out(rsp0));

  bram_wide_port #(.ADDRS(24), .BRAM_WIDTH(64), .PIECES(4), .READ_LATENCY(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst_n), .bram_dout(dout1), .bram_addr(addr1), .bram_we(we1),
    .bram_regce(regce1), .bram_din(din1), .req_valid_in(req_valid), .req_ready_out(ready1),
    .req_write_in(req_write), .req_addr_in(req_addr), .req_data_in(req_data),
    .req_mask_in(req_mask), .done_out(done1), .err_out(err1), .rsp_data_out(rsp1));

  // HIGH_PERFORMANCE model: read-first latch, then output register gated by regce.
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= din0;
    ram0 <= mem0[addr0];
    if (regce0) dout0 <= ram0;
  end

  // LOW_LATENCY model.
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= din1;
    dout1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we0) we_cnt0 <= we_cnt0 + 1;
    if (req_valid && ready0) begin
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready0 && ready1)) begin
      step();
      n++;
      if (n > 100) begin
        $display("FAIL ready_timeout observed=0 expected=1");
        $fatal(1, "ready never rose");
      end
    end
  endtask

  // Leaves the bench just after the acceptance edge E0.
  task automatic send(input logic wr, input logic [4:0] a, input logic [255:0] d, input logic [3:0] m);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    step();
    req_valid = 1'b0;
  endtask

  // Edge index (relative to E0) at which each instance raised done_out; -1 on timeout.
  task automatic wait_done(output int n0, output int n1, output logic e0, output logic e1,
                           output logic [255:0] r0, output logic [255:0] r1);
    n0 = -1; n1 = -1; e0 = 1'b0; e1 = 1'b0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 40 && (n0 < 0 || n1 < 0); c++) begin
      step();
      if (done0 && n0 < 0) begin n0 = c; e0 = err0; r0 = rsp0; end
      if (done1 && n1 < 0) begin n1 = c; e1 = err1; r1 = rsp1; end
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [255:0] d, input logic [3:0] m, input string tag);
    int n0, n1; logic e0, e1; logic [255:0] r0, r1;
    send(1'b1, a, d, m);
    wait_done(n0, n1, e0, e1, r0, r1);
    chk({tag, "_done_lat"}, 256'(n0), 256'(4));
    chk({tag, "_done_lat_l1"}, 256'(n1), 256'(4));
  endtask

  task automatic do_read(input logic [4:0] a, input logic [255:0] exp, input string tag);
    int n0, n1; logic e0, e1; logic [255:0] r0, r1;
    send(1'b0, a, '0, '0);
    wait_done(n0, n1, e0, e1, r0, r1);
    chk({tag, "_lat2"}, 256'(n0), 256'(6));
    chk({tag, "_lat1"}, 256'(n1), 256'(5));
    chk({tag, "_data2"}, r0, exp);
    chk({tag, "_data1"}, r1, exp);
    chk({tag, "_err"}, {254'd0, e1, e0}, 256'd0);
    step();
    chk({tag, "_hold"}, rsp0, exp);
  endtask

  initial begin
    int hi;
    int n0, n1; logic e0, e1; logic [255:0] r0, r1;
    int wsnap;
    for (int i = 0; i < 96; i++) begin mem0[i] = '0; mem1[i] = '0; end

    // Reset state
    step(); step(); step();
    chk("rst_ready", {255'd0, ready0}, 256'd0);
    chk("rst_ctl", {252'd0, we0, regce0, done0, err0}, 256'd0);
    chk("rst_addr", {249'd0, addr0}, 256'd0);
    chk("rst_din", {192'd0, din0}, 256'd0);
    chk("rst_rsp", rsp0, 256'd0);
    rst_n = 1'b1;
    step();
    chk("rel_ready", {254'd0, ready1, ready0}, 256'd3);

    // Full write to address 0, piece by piece
    send(1'b1, 5'd0, D1, 4'b1111);
    chk("w_addr0", {249'd0, addr0}, 256'd0);
    chk("w_piece0", {191'd0, we0, din0}, {191'd0, 1'b1, 64'h8888888888888888});
    chk("w_regce", {255'd0, regce0}, 256'd1);
    step();
    chk("w_addr1", {249'd0, addr0}, 256'd1);
    chk("w_piece1", {192'd0, din0}, {192'd0, 64'hBEAD0000BE001122});
    step();
    chk("w_addr2", {249'd0, addr0}, 256'd2);
    step();
    chk("w_addr3", {249'd0, addr0}, 256'd3);
    chk("w_piece3", {191'd0, we0, din0}, {191'd0, 1'b1, 64'hBEAD0000BE001122});
    step();
    chk("w_done_e4", {251'd0, done0, err0, we0, regce0, ready0}, {251'd0, 5'b10000});
    chk("w_done_e4_l1", {255'd0, done1}, 256'd1);
    step();
    chk("w_e5", {254'd0, done0, ready0}, {254'd0, 2'b01});

    do_read(5'd0, D1, "rd0");

    // All-zero mask: normal timing, no BRAM writes
    wsnap = we_cnt0;
    do_write(5'd0, {256{1'b1}}, 4'b0000, "wzero");
    chk("wzero_no_we", 256'(we_cnt0), 256'(wsnap));
    do_read(5'd0, D1, "rd0_again");

    // Masked write over a preloaded word
    do_write(5'd12, PRE, 4'b1111, "pre12");
    do_write(5'd12, 256'd0, 4'b0101, "mask12");
    do_read(5'd12, MSKD, "rd12");

    // Out-of-range request
    wsnap = we_cnt0;
    send(1'b0, 5'd24, '0, '0);
    wait_done(n0, n1, e0, e1, r0, r1);
    chk("oor_lat", {n1[7:0], n0[7:0]}, {8'd1, 8'd1});
    chk("oor_err", {254'd0, e1, e0}, 256'd3);
    chk("oor_rsp", r0, MSKD);
    chk("oor_no_we", 256'(we_cnt0), 256'(wsnap));
    step();
    chk("oor_e2", {253'd0, done0, err0, ready0}, {253'd0, 3'b001});

    // Back-to-back writes with valid held high
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd3; req_data = W3; req_mask = 4'hF;
    step();
    req_addr = 5'd4; req_data = W4;
    hi = ready0 ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ready0) hi++;
    end
    chk("b2b_ready_low", 256'(hi), 256'd0);
    step();
    chk("b2b_ready_e5", {255'd0, ready0}, 256'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_spacing", 256'(acc_last - acc_prev), 256'd6);
    wait_done(n0, n1, e0, e1, r0, r1);
    chk("b2b_done", 256'(n0), 256'd4);
    do_read(5'd3, W3, "rd3");
    do_read(5'd4, W4, "rd4");

    // Reset during piece 2 of a write
    send(1'b1, 5'd12, NEWW, 4'b1111);
    step(); step();
    chk("mid_addr", {249'd0, addr0}, 256'd50);
    rst_n = 1'b0;
    #1;
    chk("mid_we", {254'd0, we1, we0}, 256'd0);
    chk("mid_outs", {251'd0, regce0, ready0, done0, err0, 1'b0}, 256'd0);
    chk("mid_bus", {185'd0, addr0, din0}, 256'd0);
    chk("mid_rsp", rsp0, 256'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", {254'd0, ready1, ready0}, 256'd3);
    do_read(5'd12, AFTR, "rd_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
